brushless: RTL and testbench

Commutation controller for the three-phase BLDC drive. It synchronizes the hall sensor inputs and latches the rotor position only at PWM period boundaries, using the `PWM_synch` pulse from the motor driver. From that position and the requested drive magnitude it produces the per-phase select codes and the 11-bit duty that feed `mtr_drv`. It also flags a persistent illegal hall pattern.

---
 rtl/brushless_pkg.sv | 32 +++
 rtl/brushless_if.sv | 27 ++
 rtl/brushless_hall_sync.sv | 26 ++
 rtl/brushless.sv | 94 +++++++++
 tb/tb_brushless.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/brushless_pkg.sv
// Shared types and constants for the BLDC commutation controller.
package brushless_pkg;

    localparam int unsigned HALL_W = 3;
    localparam int unsigned DRV_W  = 12;
    localparam int unsigned DUTY_W = 11;
    localparam int unsigned CNT_W  = 3;

    // Phase select encoding consumed by mtr_drv
    typedef enum logic [1:0] {
        SEL_HIZ = 2'b00,
        SEL_REV = 2'b01,
        SEL_FWD = 2'b10,
        SEL_BRK = 2'b11
    } sel_t;

    // Hall sensor sample, ordered {G,Y,B}
    typedef struct packed {
        logic grn;
        logic ylw;
        logic blu;
    } hall_t;

    localparam logic [DUTY_W-1:0] DUTY_BASE  = 11'h400;
    localparam logic [DUTY_W-1:0] DUTY_BRAKE = 11'h600;

    // All-low and all-high hall patterns cannot occur on a healthy rotor
    function automatic logic hall_illegal(input logic [HALL_W-1:0] h);
        return (h == 3'b000) || (h == 3'b111);
    endfunction

endpackage

// File: rtl/brushless_if.sv
// Drive bus between the control loop / motor driver and the commutation controller.
//   drv_mag, brake_n, PWM_synch : control inputs to the controller
//   duty, selGrn/Ylw/Blu        : drive outputs toward mtr_drv
//   hall_fault                  : sticky illegal-rotation flag
interface brushless_if;
    import brushless_pkg::*;

    logic [DRV_W-1:0]  drv_mag;
    logic              brake_n;
    logic              PWM_synch;
    logic [DUTY_W-1:0] duty;
    logic [1:0]        selGrn;
    logic [1:0]        selYlw;
    logic [1:0]        selBlu;
    logic              hall_fault;

    modport master (
        output drv_mag, brake_n, PWM_synch,
        input  duty, selGrn, selYlw, selBlu, hall_fault
    );

    modport slave (
        input  drv_mag, brake_n, PWM_synch,
        output duty, selGrn, selYlw, selBlu, hall_fault
    );

endinterface

// File: rtl/brushless_hall_sync.sv
// Two-flop synchronizer for the three raw hall inputs.
//   clk, rst_n : clock, synchronous active-low reset
//   d          : raw asynchronous hall bits {G,Y,B}
//   q          : synchronized hall bits (stage 2)
module hall_sync
    import brushless_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HALL_W-1:0] d,
    output logic [HALL_W-1:0] q
);

    logic [HALL_W-1:0] stage1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage1 <= '0;
            q      <= '0;
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end

endmodule

// File: rtl/brushless.sv
// BLDC commutation controller: captures rotor position at PWM boundaries,
// decodes phase selects, computes duty, and flags persistent illegal halls.
//   clk, rst_n                 : clock, synchronous active-low reset
//   hallGrn, hallYlw, hallBlu  : raw asynchronous hall inputs
//   bus (slave)                : drv_mag/brake_n/PWM_synch in; duty/sel*/hall_fault out
module brushless
    import brushless_pkg::*;
#(
    parameter int unsigned FAULT_THRESH = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hallGrn,
    input  logic        hallYlw,
    input  logic        hallBlu,
    brushless_if.slave  bus
);

    localparam logic [CNT_W-1:0] THRESH = CNT_W'(FAULT_THRESH);

    hall_t             hall_raw;
    logic [HALL_W-1:0] hall_s2;
    logic [HALL_W-1:0] rot_state;
    logic [CNT_W-1:0]  ill_cnt;
    logic [CNT_W-1:0]  ill_cnt_nxt;
    logic              hall_fault_q;
    sel_t              sel_g, sel_y, sel_b;
    logic              unused_drv_lsbs;

    assign hall_raw = '{grn: hallGrn, ylw: hallYlw, blu: hallBlu};

    hall_sync u_hall_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (hall_raw),
        .q     (hall_s2)
    );

    // Fault run length for the pattern about to be captured
    always_comb begin
        ill_cnt_nxt = '0;
        if (hall_illegal(hall_s2)) begin
            ill_cnt_nxt = (ill_cnt == THRESH) ? ill_cnt : ill_cnt + CNT_W'(1);
        end
    end

    // Position capture and fault tracking, only at PWM boundaries
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rot_state    <= '0;
            ill_cnt      <= '0;
            hall_fault_q <= 1'b0;
        end else if (bus.PWM_synch) begin
            rot_state <= hall_s2;
            ill_cnt   <= ill_cnt_nxt;
            if (ill_cnt_nxt == THRESH) begin
                hall_fault_q <= 1'b1;
            end
        end
    end

    // Commutation decode with brake override
    always_comb begin
        sel_g = SEL_HIZ;
        sel_y = SEL_HIZ;
        sel_b = SEL_HIZ;
        case (rot_state)
            3'b101: begin sel_g = SEL_FWD; sel_y = SEL_REV; end
            3'b100: begin sel_g = SEL_FWD; sel_b = SEL_REV; end
            3'b110: begin sel_y = SEL_FWD; sel_b = SEL_REV; end
            3'b010: begin sel_g = SEL_REV; sel_y = SEL_FWD; end
            3'b011: begin sel_g = SEL_REV; sel_b = SEL_FWD; end
            3'b001: begin sel_y = SEL_REV; sel_b = SEL_FWD; end
            default: ;
        endcase
        if (!bus.brake_n) begin
            sel_g = SEL_BRK;
            sel_y = SEL_BRK;
            sel_b = SEL_BRK;
        end
    end

    assign bus.selGrn     = sel_g;
    assign bus.selYlw     = sel_y;
    assign bus.selBlu     = sel_b;
    assign bus.hall_fault = hall_fault_q;

    // Magnitude scaled to 10 bits on top of the mid-scale base; cannot overflow
    assign bus.duty = bus.brake_n ? (DUTY_BASE + DUTY_W'(bus.drv_mag[DRV_W-1:2]))
                                  : DUTY_BRAKE;

    assign unused_drv_lsbs = ^bus.drv_mag[1:0];

endmodule

// File: tb/tb_brushless.sv
// Self-checking bench for brushless: directed vector tables plus random
// stimulus compared against a delay-line/run-length reference model.
module tb_brushless;
    import brushless_pkg::*;

    localparam int unsigned THRESH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, hall_g, hall_y, hall_b;
    brushless_if bus();

    brushless #(.FAULT_THRESH(THRESH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .hallGrn (hall_g),
        .hallYlw (hall_y),
        .hallBlu (hall_b),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: hall values seen one and two edges ago, captured
    // position, length of the current illegal-capture run, sticky fault.
    logic [2:0] m_h1, m_h2, m_rot;
    int         m_run;
    logic       m_fault;

    typedef struct {
        logic [2:0] hall;
        logic [1:0] g, y, b;
    } rot_vec_t;

    typedef struct {
        logic        brk_n;
        logic [11:0] mag;
        logic [10:0] duty;
        logic [1:0]  sel;
    } duty_vec_t;

    rot_vec_t  rot_tab[6];
    duty_vec_t duty_tab[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Commutation table: returns {G,Y,B} select codes
    function automatic logic [5:0] ref_sel(input logic [2:0] rot, input logic brk_n);
        if (!brk_n) return 6'b11_11_11;
        case (rot)
            3'b101: return {2'd2, 2'd1, 2'd0};
            3'b100: return {2'd2, 2'd0, 2'd1};
            3'b110: return {2'd0, 2'd2, 2'd1};
            3'b010: return {2'd1, 2'd2, 2'd0};
            3'b011: return {2'd1, 2'd0, 2'd2};
            3'b001: return {2'd0, 2'd1, 2'd2};
            default: return 6'b0;
        endcase
    endfunction

    function automatic int ref_duty(input logic brk_n, input logic [11:0] mag);
        if (!brk_n) return 'h600;
        return 'h400 + int'(mag) / 4;
    endfunction

    // Advance the model by one rising edge using the inputs now applied
    function void model_edge();
        logic [2:0] h;
        h = {hall_g, hall_y, hall_b};
        if (!rst_n) begin
            m_h1 = 3'b0; m_h2 = 3'b0; m_rot = 3'b0;
            m_run = 0; m_fault = 1'b0;
        end else begin
            if (bus.PWM_synch) begin
                m_rot = m_h2;
                if (m_rot == 3'b000 || m_rot == 3'b111) m_run++;
                else m_run = 0;
                if (m_run >= int'(THRESH)) m_fault = 1'b1;
            end
            m_h2 = m_h1;
            m_h1 = h;
        end
    endfunction

    task automatic compare_model();
        logic [5:0] s;
        s = ref_sel(m_rot, bus.brake_n);
        check("m_selGrn", 32'(bus.selGrn), 32'(s[5:4]));
        check("m_selYlw", 32'(bus.selYlw), 32'(s[3:2]));
        check("m_selBlu", 32'(bus.selBlu), 32'(s[1:0]));
        check("m_duty", 32'(bus.duty), 32'(ref_duty(bus.brake_n, bus.drv_mag)));
        check("m_fault", 32'(bus.hall_fault), 32'(m_fault));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    task automatic set_hall(input logic [2:0] h);
        {hall_g, hall_y, hall_b} = h;
    endtask

    // Present a hall pattern, let it settle through the synchronizer, then capture
    task automatic capture(input logic [2:0] h);
        set_hall(h);
        tick();
        tick();
        bus.PWM_synch = 1'b1;
        tick();
        bus.PWM_synch = 1'b0;
    endtask

    task automatic check_sels(input string name, input logic [1:0] g, input logic [1:0] y,
                              input logic [1:0] b);
        check({name, "_grn"}, 32'(bus.selGrn), 32'(g));
        check({name, "_ylw"}, 32'(bus.selYlw), 32'(y));
        check({name, "_blu"}, 32'(bus.selBlu), 32'(b));
    endtask

    initial begin
        rot_tab[0] = '{3'b101, 2'b10, 2'b01, 2'b00};
        rot_tab[1] = '{3'b100, 2'b10, 2'b00, 2'b01};
        rot_tab[2] = '{3'b110, 2'b00, 2'b10, 2'b01};
        rot_tab[3] = '{3'b010, 2'b01, 2'b10, 2'b00};
        rot_tab[4] = '{3'b011, 2'b01, 2'b00, 2'b10};
        rot_tab[5] = '{3'b001, 2'b00, 2'b01, 2'b10};

        duty_tab[0] = '{1'b1, 12'hFFF, 11'h7FF, 2'b00};
        duty_tab[1] = '{1'b1, 12'h800, 11'h600, 2'b00};
        duty_tab[2] = '{1'b1, 12'h000, 11'h400, 2'b00};
        duty_tab[3] = '{1'b1, 12'h003, 11'h400, 2'b00};
        duty_tab[4] = '{1'b1, 12'h004, 11'h401, 2'b00};
        duty_tab[5] = '{1'b0, 12'h123, 11'h600, 2'b11};
        duty_tab[6] = '{1'b0, 12'hFFF, 11'h600, 2'b11};

        m_h1 = 3'b0; m_h2 = 3'b0; m_rot = 3'b0; m_run = 0; m_fault = 1'b0;
        rst_n = 1'b0;
        set_hall(3'b000);
        bus.drv_mag   = 12'h000;
        bus.brake_n   = 1'b1;
        bus.PWM_synch = 1'b0;
        @(negedge clk);

        // Reset state
        tick();
        tick();
        check_sels("reset", 2'b00, 2'b00, 2'b00);
        check("reset_duty", 32'(bus.duty), 32'h400);
        check("reset_fault", 32'(bus.hall_fault), 32'h0);
        rst_n = 1'b1;
        tick();

        // Duty and brake are combinational; rot_state is 000 so non-brake selects are HIZ
        for (int i = 0; i < 7; i++) begin
            bus.brake_n = duty_tab[i].brk_n;
            bus.drv_mag = duty_tab[i].mag;
            #1;
            check($sformatf("duty_vec%0d", i), 32'(bus.duty), 32'(duty_tab[i].duty));
            check_sels($sformatf("brk_vec%0d", i), duty_tab[i].sel, duty_tab[i].sel,
                       duty_tab[i].sel);
        end
        bus.brake_n = 1'b1;
        bus.drv_mag = 12'h200;
        @(negedge clk);
        compare_model();

        // Full rotation, with stability between pulses
        for (int i = 0; i < 6; i++) begin
            capture(rot_tab[i].hall);
            check_sels($sformatf("rot%0d", i), rot_tab[i].g, rot_tab[i].y, rot_tab[i].b);
            for (int k = 0; k < 3; k++) tick();
            check_sels($sformatf("rot%0d_hold", i), rot_tab[i].g, rot_tab[i].y, rot_tab[i].b);
        end

        // Capture gating: no pulse for 20 cycles leaves selects on 001 decode
        set_hall(3'b101);
        for (int k = 0; k < 20; k++) tick();
        check_sels("gate_hold", 2'b00, 2'b01, 2'b10);
        bus.PWM_synch = 1'b1;
        tick();
        bus.PWM_synch = 1'b0;
        check_sels("gate_cap", 2'b10, 2'b01, 2'b00);

        // Brake mid-rotation forces 11 in the same cycle, releases back to decode
        bus.brake_n = 1'b0;
        #1;
        check_sels("brake_on", 2'b11, 2'b11, 2'b11);
        check("brake_duty", 32'(bus.duty), 32'h600);
        bus.brake_n = 1'b1;
        #1;
        check_sels("brake_off", 2'b10, 2'b01, 2'b00);
        @(negedge clk);
        compare_model();

        // Two illegal captures followed by a legal one: no fault
        capture(3'b111);
        bus.PWM_synch = 1'b1;
        tick();
        bus.PWM_synch = 1'b0;
        check("ill2_cnt", 32'(dut.ill_cnt), 32'd2);
        check("ill2_fault", 32'(bus.hall_fault), 32'h0);
        capture(3'b101);
        check("legal_cnt", 32'(dut.ill_cnt), 32'd0);
        check("legal_fault", 32'(bus.hall_fault), 32'h0);

        // Three illegal captures set the sticky flag; threshold boundary checked
        capture(3'b000);
        bus.PWM_synch = 1'b1;
        tick();
        bus.PWM_synch = 1'b0;
        check("thr_m1_fault", 32'(bus.hall_fault), 32'h0);
        bus.PWM_synch = 1'b1;
        tick();
        bus.PWM_synch = 1'b0;
        check("thr_fault", 32'(bus.hall_fault), 32'h1);
        check("thr_cnt", 32'(dut.ill_cnt), 32'(THRESH));
        bus.PWM_synch = 1'b1;
        tick();
        bus.PWM_synch = 1'b0;
        check("thr_sat_cnt", 32'(dut.ill_cnt), 32'(THRESH));
        capture(3'b101);
        check("sticky_fault", 32'(bus.hall_fault), 32'h1);
        check("sticky_cnt", 32'(dut.ill_cnt), 32'd0);

        // Reset mid-operation, coincident with a pulse
        capture(3'b110);
        check_sels("pre_rst", 2'b00, 2'b10, 2'b01);
        rst_n = 1'b0;
        bus.PWM_synch = 1'b1;
        tick();
        check_sels("mid_rst", 2'b00, 2'b00, 2'b00);
        check("mid_rst_cnt", 32'(dut.ill_cnt), 32'd0);
        check("mid_rst_fault", 32'(bus.hall_fault), 32'h0);
        rst_n = 1'b1;
        bus.PWM_synch = 1'b0;
        capture(3'b110);
        check_sels("post_rst", 2'b00, 2'b10, 2'b01);
        check("post_rst_fault", 32'(bus.hall_fault), 32'h0);

        // Random stimulus against the model
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(5) == 0) set_hall(3'($urandom_range(7)));
            bus.PWM_synch = ($urandom_range(3) == 0);
            bus.brake_n   = ($urandom_range(9) != 0);
            bus.drv_mag   = 12'($urandom_range(4095));
            rst_n         = ($urandom_range(199) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
